// File: rtl/inner_product_ctrl_pkg.sv
// Types and helpers shared by the inner-product controller and its loop counter.
package inner_product_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } ip_state_e;

    // PE_LATENCY is bounded to 1..15, so four bits always hold the drain count.
    localparam int DRAIN_W = 4;

    function automatic int ceil_a_by_b(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/inner_product_ctrl_loop_counter.sv
// Wrapping loop index: advances on i_en, wraps to 0 after i_max, i_clr restarts it.
// Zero latency on o_last; holds its value whenever i_en is low (stall).
module ip_loop_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_last
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == i_max) ? '0 : r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == i_max);

endmodule

// File: rtl/inner_product_ctrl.sv
// Sequences reads, MAC enables, drain and result writes for one fully-connected layer.
// mac_en/wt_addr follow a read handshake by one cycle; pu_rd_ready low stalls all counters.
module inner_product_ctrl
    import inner_product_ctrl_pkg::*;
#(
    parameter int NUM_PE     = 1,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int PE_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_num_in,
    input  logic [CNT_WIDTH-1:0]  cfg_num_out,
    input  logic                  pu_rd_ready,
    output logic                  pu_rd_req,
    output logic                  mac_en,
    output logic                  acc_clr,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    output logic                  pu_wr_req,
    output logic                  busy,
    output logic                  done
);

    if (PE_LATENCY < 1 || PE_LATENCY > 15 || NUM_PE < 1) begin : g_bad_param
        $error("inner_product_ctrl: PE_LATENCY must be 1..15 and NUM_PE >= 1");
    end

    ip_state_e             r_state;
    logic [CNT_WIDTH-1:0]  r_num_in;
    logic [CNT_WIDTH-1:0]  r_num_out;
    logic [DRAIN_W-1:0]    r_drain;
    logic                  r_mac_en;
    logic                  r_acc_clr;
    logic [ADDR_WIDTH-1:0] r_wt_addr;

    logic                  w_cfg_zero;
    logic                  w_launch;
    logic                  w_xfer;
    logic                  w_write;
    logic                  w_in_last;
    logic                  w_out_last;
    logic [CNT_WIDTH-1:0]  w_in_idx;
    logic [CNT_WIDTH-1:0]  w_out_idx;
    logic [CNT_WIDTH-1:0]  w_in_max;
    logic [CNT_WIDTH-1:0]  w_out_max;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    assign w_cfg_zero = (cfg_num_in == '0) || (cfg_num_out == '0);
    assign w_launch   = (r_state == ST_IDLE) && start && !w_cfg_zero;
    assign w_xfer     = (r_state == ST_READ) && pu_rd_ready;
    assign w_write    = (r_state == ST_WRITE);
    assign w_in_max   = r_num_in - CNT_WIDTH'(1);
    assign w_out_max  = r_num_out - CNT_WIDTH'(1);

    ip_loop_counter #(.WIDTH(CNT_WIDTH)) u_in_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_launch),
        .i_en   (w_xfer),
        .i_max  (w_in_max),
        .o_cnt  (w_in_idx),
        .o_last (w_in_last)
    );

    ip_loop_counter #(.WIDTH(CNT_WIDTH)) u_out_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_launch),
        .i_en   (w_write),
        .i_max  (w_out_max),
        .o_cnt  (w_out_idx),
        .o_last (w_out_last)
    );

    // Product is formed at full address width so large layers never alias.
    assign w_addr_next = ADDR_WIDTH'(w_out_idx) * ADDR_WIDTH'(r_num_in) + ADDR_WIDTH'(w_in_idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_num_in  <= '0;
            r_num_out <= '0;
            r_drain   <= '0;
            r_mac_en  <= 1'b0;
            r_acc_clr <= 1'b0;
            r_wt_addr <= '0;
        end else begin
            r_mac_en  <= w_xfer;
            r_acc_clr <= w_xfer && (w_in_idx == '0);
            if (w_xfer) begin
                r_wt_addr <= w_addr_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_zero) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_num_in  <= cfg_num_in;
                            r_num_out <= cfg_num_out;
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_xfer && w_in_last) begin
                        r_drain <= DRAIN_W'(PE_LATENCY);
                        r_state <= ST_DRAIN;
                    end
                end
                // Counter starts at PE_LATENCY on the cycle of the last mac_en.
                ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end
                end
                ST_WRITE: begin
                    r_state <= w_out_last ? ST_FIN : ST_READ;
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pu_rd_req = (r_state == ST_READ);
    assign pu_wr_req = (r_state == ST_WRITE);
    assign busy      = (r_state == ST_READ) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
    assign done      = (r_state == ST_FIN);
    assign mac_en    = r_mac_en;
    assign acc_clr   = r_acc_clr;
    assign wt_addr   = r_wt_addr;

endmodule

// File: tb/tb_inner_product_ctrl.sv
// Layer-schedule model of the controller checked against the DUT every cycle.
module tb_inner_product_ctrl;

    localparam int PE_LAT = 3;
    localparam int MAXC   = 16384;
    localparam int S_MAC = 0, S_CLR = 1, S_WR = 2, S_BUSY = 3, S_DONE = 4, S_RDREQ = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pu_rd_ready = 1'b0;
    logic [15:0] cfg_num_in = '0;
    logic [15:0] cfg_num_out = '0;
    logic        pu_rd_req, mac_en, acc_clr, pu_wr_req, busy, done;
    logic [31:0] wt_addr;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    bit rdy_pat   [MAXC];
    bit exp_rdreq [MAXC];
    bit exp_mac   [MAXC];
    bit exp_clr   [MAXC];
    bit exp_wr    [MAXC];
    bit exp_busy  [MAXC];
    bit exp_done  [MAXC];
    int exp_addr  [MAXC];
    bit obs_rdreq [MAXC];
    bit obs_mac   [MAXC];
    bit obs_clr   [MAXC];
    bit obs_wr    [MAXC];
    bit obs_busy  [MAXC];
    bit obs_done  [MAXC];
    int obs_addr  [MAXC];

    inner_product_ctrl #(
        .NUM_PE     (1),
        .CNT_WIDTH  (16),
        .ADDR_WIDTH (32),
        .PE_LATENCY (PE_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_num_in  (cfg_num_in),
        .cfg_num_out (cfg_num_out),
        .pu_rd_ready (pu_rd_ready),
        .pu_rd_req   (pu_rd_req),
        .mac_en      (mac_en),
        .acc_clr     (acc_clr),
        .wt_addr     (wt_addr),
        .pu_wr_req   (pu_wr_req),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval following rising edge n; ready is applied 1 ns into it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        pu_rd_ready = (cyc < MAXC) ? rdy_pat[cyc] : 1'b1;
    end

    task automatic chk(input string nm, input int cy, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cy, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            obs_rdreq[cyc] = pu_rd_req;
            obs_mac[cyc]   = mac_en;
            obs_clr[cyc]   = acc_clr;
            obs_wr[cyc]    = pu_wr_req;
            obs_busy[cyc]  = busy;
            obs_done[cyc]  = done;
            obs_addr[cyc]  = int'(wt_addr);
            chk("pu_rd_req", cyc, pu_rd_req, exp_rdreq[cyc]);
            chk("mac_en", cyc, mac_en, exp_mac[cyc]);
            chk("acc_clr", cyc, acc_clr, exp_clr[cyc]);
            chk("pu_wr_req", cyc, pu_wr_req, exp_wr[cyc]);
            chk("busy", cyc, busy, exp_busy[cyc]);
            chk("done", cyc, done, exp_done[cyc]);
            if (exp_mac[cyc]) chk("wt_addr", cyc, wt_addr, exp_addr[cyc]);
        end
    end

    // Builds the expected output timeline for a layer whose start is driven in cycle s.
    function automatic int plan(int s, int n_in, int n_out);
        int c;
        int w;
        if (n_in == 0 || n_out == 0) begin
            exp_done[s+1] = 1'b1;
            return s + 1;
        end
        c = s + 1;
        for (int g = 0; g < n_out; g++) begin
            for (int i = 0; i < n_in; i++) begin
                while (!rdy_pat[c] && c < MAXC - 64) begin
                    exp_rdreq[c] = 1'b1;
                    exp_busy[c]  = 1'b1;
                    c++;
                end
                exp_rdreq[c]  = 1'b1;
                exp_busy[c]   = 1'b1;
                exp_mac[c+1]  = 1'b1;
                exp_addr[c+1] = g * n_in + i;
                exp_clr[c+1]  = (i == 0);
                c++;
            end
            // Result is written PE_LAT+1 cycles after the group's last mac_en.
            w = c + PE_LAT + 1;
            for (int k = c; k <= w; k++) exp_busy[k] = 1'b1;
            exp_wr[w] = 1'b1;
            c = w + 1;
        end
        exp_done[c] = 1'b1;
        return c;
    endfunction

    function automatic int count(int sel, int a, int b);
        int n = 0;
        for (int c = a; c <= b; c++) begin
            case (sel)
                S_MAC:   n += int'(obs_mac[c]);
                S_CLR:   n += int'(obs_clr[c]);
                S_WR:    n += int'(obs_wr[c]);
                S_BUSY:  n += int'(obs_busy[c]);
                S_DONE:  n += int'(obs_done[c]);
                default: n += int'(obs_rdreq[c]);
            endcase
        end
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic fill_ready(input int s, input int mode);
        for (int c = s; c < s + 1200 && c < MAXC; c++) begin
            rdy_pat[c] = (mode == 0) ? 1'b1 :
                         (mode == 1) ? ((c - s) % 2 == 1) :
                         ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic launch(input int n_in, input int n_out, input int mode, input int repulse,
                          output int s, output int e);
        s = cyc;
        fill_ready(s, mode);
        e = plan(s, n_in, n_out);
        start = 1'b1;
        cfg_num_in = 16'(n_in);
        cfg_num_out = 16'(n_out);
        tick(1);
        start = 1'b0;
        cfg_num_in = 16'($urandom);
        cfg_num_out = 16'($urandom);
        if (repulse > 0) begin
            tick(repulse - 1);
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
    endtask

    task automatic check_addr_order(input string nm, input int s, input int e, input int total);
        int k = 0;
        for (int c = s; c <= e; c++) begin
            if (obs_mac[c]) begin
                chk(nm, c, obs_addr[c], k);
                k++;
            end
        end
        chk({nm, "_count"}, e, k, total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, ni, no, rp;
        tick(3);
        chk("rst_wt_addr", cyc, wt_addr, 0);
        chk("rst_busy", cyc, busy, 0);
        chk("rst_done", cyc, done, 0);
        chk("rst_mac_en", cyc, mac_en, 0);
        chk("rst_rd_req", cyc, pu_rd_req, 0);
        reset = 1'b0;
        tick(2);

        // 4x2, always ready
        launch(4, 2, 0, 0, s, e);
        wait_until(e + 2);
        chk("A_end", s, e - s, 19);
        chk("A_writes", s, count(S_WR, s, e + 1), 2);
        chk("A_wr0_at", s + 9, obs_wr[s+9], 1);
        chk("A_wr1_at", s + 18, obs_wr[s+18], 1);
        chk("A_done_at", s + 19, obs_done[s+19], 1);
        chk("A_done_cnt", s, count(S_DONE, s, e + 1), 1);
        chk("A_clr_at0", s + 2, obs_clr[s+2], 1);
        chk("A_clr_at4", s + 11, obs_clr[s+11], 1);
        chk("A_clr_cnt", s, count(S_CLR, s, e + 1), 2);
        check_addr_order("A_addr", s, e + 1, 8);

        // 4x2, ready toggling 1/0
        launch(4, 2, 1, 0, s, e);
        wait_until(e + 2);
        check_addr_order("B_addr", s, e + 1, 8);
        chk("B_writes", s, count(S_WR, s, e + 1), 2);

        // zero input count
        launch(0, 5, 0, 0, s, e);
        wait_until(e + 2);
        chk("C_done_at", s + 1, obs_done[s+1], 1);
        chk("C_busy_cnt", s, count(S_BUSY, s, e + 1), 0);
        chk("C_rdreq_cnt", s, count(S_RDREQ, s, e + 1), 0);
        chk("C_wr_cnt", s, count(S_WR, s, e + 1), 0);

        // start re-pulsed during READ with changed cfg
        launch(4, 2, 0, 2, s, e);
        wait_until(e + 2);
        chk("D_macs", s, count(S_MAC, s, e + 1), 8);
        chk("D_writes", s, count(S_WR, s, e + 1), 2);

        // one input per group
        launch(1, 3, 0, 0, s, e);
        wait_until(e + 2);
        chk("E_clr_cnt", s, count(S_CLR, s, e + 1), 3);
        chk("E_writes", s, count(S_WR, s, e + 1), 3);
        check_addr_order("E_addr", s, e + 1, 3);

        // reset during DRAIN of group 0
        s = cyc;
        fill_ready(s, 0);
        e = plan(s, 4, 2);
        start = 1'b1;
        cfg_num_in = 16'd4;
        cfg_num_out = 16'd2;
        tick(1);
        start = 1'b0;
        tick(5);
        for (int c = s + 6; c <= e + 2; c++) begin
            exp_rdreq[c] = 1'b0; exp_mac[c] = 1'b0; exp_clr[c] = 1'b0;
            exp_wr[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("F_busy_now", cyc, busy, 0);
        chk("F_addr_now", cyc, wt_addr, 0);
        tick(2);
        reset = 1'b0;
        wait_until(e + 2);
        chk("F_writes", s, count(S_WR, s, e + 1), 0);
        launch(3, 1, 0, 0, s, e);
        wait_until(e + 2);
        chk("F2_macs", s, count(S_MAC, s, e + 1), 3);
        chk("F2_writes", s, count(S_WR, s, e + 1), 1);

        // randomized layers with random backpressure
        for (int t = 0; t < 10; t++) begin
            ni = $urandom_range(0, 5);
            no = $urandom_range(1, 4);
            rp = (ni != 0 && $urandom_range(0, 1) == 1) ? 2 : 0;
            launch(ni, no, 2, rp, s, e);
            wait_until(e + 2);
            chk("R_macs", s, count(S_MAC, s, e + 1), ni * no);
            chk("R_writes", s, count(S_WR, s, e + 1), (ni == 0) ? 0 : no);
        end

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
